// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR: state encoding, default taps and
// the small compile-time helpers used to size and address the datapath.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_OUT    = 2'd2,
        ST_CONFIG = 2'd3
    } fir_state_t;

    // Slice i is coefficient i: coef0 = -3, coef1 = 2, coef2 = 3.
    localparam logic [8:0] COEF_INIT_DEFAULT = {3'b011, 3'b010, 3'b101};

    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Mirrored taps reuse the stored coefficients in reverse past the centre.
    function automatic int tap_coef_index(input int k, input int ntaps, input int len);
        return (k < ntaps) ? k : (len - 1 - k);
    endfunction

endpackage

// File: rtl/fir_serial_gen_if.sv
// Sample-in / result-out handshake bundle of the serial FIR.
// The master side is the sample source plus downstream sink; the slave is the filter.
interface fir_serial_gen_if #(
    parameter int X_W = 8,
    parameter int Y_W = 11
);
    logic [X_W-1:0] x_n;
    logic           s_axis_fir_tvalid;
    logic           s_axis_fir_tready;
    logic           s_set_coeffs;
    logic [Y_W-1:0] m_axis_fir_tdata;
    logic           m_axis_fir_tvalid;
    logic           m_axis_fir_tready;

    modport master (
        output x_n, s_axis_fir_tvalid, s_set_coeffs, m_axis_fir_tready,
        input  s_axis_fir_tready, m_axis_fir_tdata, m_axis_fir_tvalid
    );

    modport slave (
        input  x_n, s_axis_fir_tvalid, s_set_coeffs, m_axis_fir_tready,
        output s_axis_fir_tready, m_axis_fir_tdata, m_axis_fir_tvalid
    );
endinterface

// File: rtl/fir_mac_sat.sv
// Single signed multiply-accumulate with a look-ahead saturated view of the
// next accumulator value, so the final MAC result can be registered directly.
module fir_mac_sat #(
    parameter int COEF_W = 3,
    parameter int X_W    = 8,
    parameter int Y_W    = 11,
    parameter int ACC_W  = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [X_W-1:0]    sample,
    output logic signed [Y_W-1:0]    sat_next
);
    localparam int PW    = COEF_W + X_W;
    localparam int CMP_W = (ACC_W > Y_W) ? ACC_W : Y_W;
    localparam logic signed [CMP_W-1:0] Y_MAX = {{(CMP_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] Y_MIN = {{(CMP_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};

    logic signed [PW-1:0]    product;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [CMP_W-1:0] acc_wide;

    // Full-precision product added to the accumulator, then clamped into the output range.
    always_comb begin
        product  = PW'(coef) * PW'(sample);
        acc_next = acc + ACC_W'(product);
        acc_wide = CMP_W'(acc_next);
        if (acc_wide > Y_MAX) begin
            sat_next = Y_MAX[Y_W-1:0];
        end else if (acc_wide < Y_MIN) begin
            sat_next = Y_MIN[Y_W-1:0];
        end else begin
            sat_next = acc_wide[Y_W-1:0];
        end
    end

    // Accumulator: cleared when a new sample is taken, advanced once per tap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/fir_serial_gen.sv
// Serial FIR: one accepted sample yields one saturated output after walking a
// single MAC across the (optionally mirrored) tap history.
module fir_serial_gen
    import fir_pkg::*;
#(
    parameter int                      COEF_W    = 3,
    parameter int                      NTAPS     = 3,
    parameter int                      X_W       = 8,
    parameter int                      Y_W       = 11,
    parameter int                      SYMMETRIC = 1,
    parameter logic [COEF_W*NTAPS-1:0] COEF_INIT = COEF_INIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    fir_serial_gen_if.slave bus
);
    localparam int L     = (SYMMETRIC != 0) ? (2 * NTAPS - 1) : NTAPS;
    localparam int KW    = (clog2(L) > 0) ? clog2(L) : 1;
    localparam int CIW   = (clog2(NTAPS) > 0) ? clog2(NTAPS) : 1;
    localparam int ACC_W = X_W + COEF_W + clog2(L);

    fir_state_t               state;
    logic [KW-1:0]            k;
    logic signed [X_W-1:0]    dl [L];
    logic signed [COEF_W-1:0] coef [NTAPS];
    logic [Y_W-1:0]           tdata_q;
    logic                     tvalid_q;
    logic                     s_ready;
    logic                     accept;
    logic [CIW-1:0]           coef_idx;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [X_W-1:0]    mac_sample;
    logic signed [Y_W-1:0]    mac_sat_next;

    assign bus.s_axis_fir_tready = s_ready;
    assign bus.m_axis_fir_tdata  = tdata_q;
    assign bus.m_axis_fir_tvalid = tvalid_q;

    // Input side is only open in IDLE, and a coefficient-load request closes it.
    always_comb begin
        s_ready    = (state == ST_IDLE) && !bus.s_set_coeffs && !reset;
        accept     = s_ready && bus.s_axis_fir_tvalid;
        coef_idx   = CIW'(tap_coef_index(int'(k), NTAPS, L));
        mac_coef   = coef[coef_idx];
        mac_sample = dl[k];
    end

    fir_mac_sat #(
        .COEF_W(COEF_W),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (state == ST_CALC),
        .coef    (mac_coef),
        .sample  (mac_sample),
        .sat_next(mac_sat_next)
    );

    // Control FSM together with the delay line, coefficient file and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            k        <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            for (int i = 0; i < L; i++) dl[i] <= '0;
            for (int i = 0; i < NTAPS; i++) coef[i] <= COEF_INIT[i*COEF_W +: COEF_W];
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.s_set_coeffs) begin
                        coef[0] <= bus.x_n[COEF_W-1:0];
                        for (int i = 1; i < NTAPS; i++) coef[i] <= coef[i-1];
                        state <= ST_CONFIG;
                    end else if (bus.s_axis_fir_tvalid) begin
                        dl[0] <= bus.x_n;
                        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
                        k     <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    k <= k + KW'(1);
                    if (k == KW'(L - 1)) begin
                        tdata_q  <= mac_sat_next;
                        tvalid_q <= 1'b1;
                        state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.m_axis_fir_tready) begin
                        tvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_CONFIG: begin
                    if (bus.s_set_coeffs) begin
                        coef[0] <= bus.x_n[COEF_W-1:0];
                        for (int i = 1; i < NTAPS; i++) coef[i] <= coef[i-1];
                    end else begin
                        for (int i = 0; i < L; i++) dl[i] <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
